ex_stage: RTL

Execute stage of the five-stage pipelined CPU. It consumes the ID/EX pipeline register outputs, forwards operands from MEM/WB, and computes ALU results, store data and branch resolution. It runs a multi-cycle iterative multiplier that stalls the front end. The EX/MEM pipeline register is built into this block, which feeds the MEM stage directly.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/mul_iter.sv | 63 ++++++
 rtl/ex_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU/funct codes, forwarding
// selects, FSM states and the EX/MEM bundle.
package cpu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
    localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
    localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
    localparam logic [9:0] FUNCT_OR  = 10'b0000000_110;
    localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int MUL_CNT_W = 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       mr;
        logic       m2r;
        logic [4:0] rd;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] alures;
        logic [31:0] wrdata;
        logic        bt;
        logic [31:0] btgt;
    } ex_mem_t;

    // Select 11 falls back to the ID/EX value
    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] id,
        input logic [31:0] mem,
        input logic [31:0] wb
    );
        logic [31:0] r;
        r = id;
        unique case (sel)
            FWD_MEM: r = mem;
            FWD_WB:  r = wb;
            default: r = id;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, low 32 bits of the product,
// MUL_BITS_PER_CYCLE multiplier bits retired per clock.
module mul_iter
    import cpu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] prod_o
);

    localparam int N = 32 / MUL_BITS_PER_CYCLE;

    logic [MUL_CNT_W-1:0] cnt_q;
    logic [31:0]          acc_q;
    logic [31:0]          mcand_q;
    logic [31:0]          mplier_q;
    logic [31:0]          step;
    logic [31:0]          acc_nxt;

    always_comb begin
        step = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) begin
                step = step + (mcand_q << j);
            end
        end
    end

    // prod_o includes the bits retired this cycle, so it is the full
    // product during the final (done) cycle.
    assign acc_nxt = acc_q + step;
    assign prod_o  = acc_nxt;
    assign done_o  = (cnt_q == MUL_CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (abort_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q    <= MUL_CNT_W'(N);
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - MUL_CNT_W'(1);
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
            mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative
// multiply with front-end stall, and the EX/MEM pipeline register.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  ALUOp_i,
    input  logic        ALUSrc_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        Mem2Reg_i,
    input  logic        Branch_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] RSdata_i,
    input  logic [31:0] RTdata_i,
    input  logic [31:0] imm_i,
    input  logic [9:0]  funct_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [1:0]  fwdA_i,
    input  logic [1:0]  fwdB_i,
    input  logic [31:0] MEMfwd_i,
    input  logic [31:0] WBfwd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic        Mem2Reg_o,
    output logic [31:0] ALUres_o,
    output logic [31:0] WRdata_o,
    output logic [4:0]  RDaddr_o,
    output logic        branch_taken_o,
    output logic [31:0] branch_target_o
);

    logic [31:0] op_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic [31:0] br_tgt;
    logic [31:0] mul_prod;
    logic        is_mul;
    logic        is_f;
    logic        mul_start;
    logic        mul_done;

    ex_state_e state_q;
    ex_state_e state_d;
    ctl_t      cap_q;
    ex_mem_t   exm_q;
    ex_mem_t   exm_d;

    assign op_a   = fwd_mux(fwdA_i, RSdata_i, MEMfwd_i, WBfwd_i);
    assign fwd_b  = fwd_mux(fwdB_i, RTdata_i, MEMfwd_i, WBfwd_i);
    assign op_b   = ALUSrc_i ? imm_i : fwd_b;
    assign diff   = op_a - op_b;
    assign br_tgt = pc_i + {imm_i[30:0], 1'b0};
    assign is_f   = (ALUOp_i == ALUOP_FUNCT);
    assign is_mul = is_f && (funct_i == FUNCT_MUL);

    always_comb begin
        alu_res = op_a + op_b;
        unique case (1'b1)
            (ALUOp_i == ALUOP_SUB):         alu_res = diff;
            (is_f && funct_i == FUNCT_SUB): alu_res = diff;
            (is_f && funct_i == FUNCT_AND): alu_res = op_a & op_b;
            (is_f && funct_i == FUNCT_OR):  alu_res = op_a | op_b;
            default:                        ;
        endcase
    end

    mul_iter #(
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(mul_start),
        .abort_i(flush_i),
        .a_i    (op_a),
        .b_i    (op_b),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    // exm_d defaults to a bubble; only a live instruction overrides it
    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        mul_start = 1'b0;
        exm_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (is_mul) begin
                    stall_o   = 1'b1;
                    mul_start = 1'b1;
                    state_d   = S_BUSY;
                end else begin
                    exm_d.ctl.rw  = RegWrite_i;
                    exm_d.ctl.mw  = MemWrite_i;
                    exm_d.ctl.mr  = MemRead_i;
                    exm_d.ctl.m2r = Mem2Reg_i;
                    exm_d.ctl.rd  = RDaddr_i;
                    exm_d.alures  = alu_res;
                    exm_d.wrdata  = fwd_b;
                    exm_d.bt      = Branch_i & (diff == '0);
                    exm_d.btgt    = br_tgt;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (mul_done) begin
                    state_d      = S_IDLE;
                    exm_d.ctl    = cap_q;
                    exm_d.alures = mul_prod;
                end else begin
                    stall_o = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            exm_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            exm_q   <= exm_d;
            if (mul_start) begin
                cap_q <= '{rw:  RegWrite_i,
                           mw:  MemWrite_i,
                           mr:  MemRead_i,
                           m2r: Mem2Reg_i,
                           rd:  RDaddr_i};
            end
        end
    end

    assign RegWrite_o      = exm_q.ctl.rw;
    assign MemWrite_o      = exm_q.ctl.mw;
    assign MemRead_o       = exm_q.ctl.mr;
    assign Mem2Reg_o       = exm_q.ctl.m2r;
    assign RDaddr_o        = exm_q.ctl.rd;
    assign ALUres_o        = exm_q.alures;
    assign WRdata_o        = exm_q.wrdata;
    assign branch_taken_o  = exm_q.bt;
    assign branch_target_o = exm_q.btgt;

endmodule
